pc_unit: RTL and testbench

//  Program-counter and fetch-address stage feeding the control path: owns the PC and drives
//  rom_addr into the ROM / instruction register. Each enabled cycle it applies one PC operation

---
 rtl/pc_unit_pkg.sv | 67 ++++++
 rtl/pc_unit_if.sv | 27 ++
 rtl/pc_unit_ret_stack.sv | 54 +++++
 rtl/pc_unit.sv | 88 ++++++++
 tb/tb_pc_unit.sv | 134 +++++++++++++
 5 files changed

// File: rtl/pc_unit_pkg.sv
// Control-path encodings shared by the PC stage and its neighbours.
// Holds the PC operations, the branch condition codes, the ALU status bit positions and the condition evaluator.
package controlpath_pkg;

  typedef enum logic [2:0] {
    PC_OP_HOLD = 3'b000,
    PC_OP_INC  = 3'b001,
    PC_OP_BR   = 3'b010,
    PC_OP_JMP  = 3'b011,
    PC_OP_JR   = 3'b100,
    PC_OP_CALL = 3'b101,
    PC_OP_RET  = 3'b110,
    PC_OP_RSVD = 3'b111
  } pc_op_e;

  typedef enum logic [3:0] {
    COND_AL = 4'h0,
    COND_EQ = 4'h1,
    COND_NE = 4'h2,
    COND_CS = 4'h3,
    COND_CC = 4'h4,
    COND_MI = 4'h5,
    COND_PL = 4'h6,
    COND_VS = 4'h7,
    COND_VC = 4'h8,
    COND_HI = 4'h9,
    COND_LS = 4'hA,
    COND_GE = 4'hB,
    COND_LT = 4'hC,
    COND_GT = 4'hD,
    COND_LE = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  localparam int unsigned ST_V = 3;
  localparam int unsigned ST_C = 2;
  localparam int unsigned ST_N = 1;
  localparam int unsigned ST_Z = 0;

  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] status);
    logic v, c, n, z, res;
    v = status[ST_V];
    c = status[ST_C];
    n = status[ST_N];
    z = status[ST_Z];
    case (cond_e'(cond))
      COND_AL: res = 1'b1;
      COND_EQ: res = z;
      COND_NE: res = !z;
      COND_CS: res = c;
      COND_CC: res = !c;
      COND_MI: res = n;
      COND_PL: res = !n;
      COND_VS: res = v;
      COND_VC: res = !v;
      COND_HI: res = c && !z;
      COND_LS: res = !c || z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = !z && (n == v);
      COND_LE: res = z || (n != v);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Control-unit <-> PC stage bundle.
// The control unit (master) drives the operation; the PC stage (slave) returns the fetch address and the stack flags.
interface pc_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              pc_en;
  logic [2:0]        pc_op;
  logic [3:0]        cond;
  logic [3:0]        status;
  logic [63:0]       k;
  logic [63:0]       reg_in;
  logic [ADDR_W-1:0] rom_addr;
  logic [ADDR_W-1:0] pc_plus4;
  logic              stk_full;
  logic              stk_empty;
  logic              stk_err;

  modport master (
    output pc_en, pc_op, cond, status, k, reg_in,
    input  rom_addr, pc_plus4, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  pc_en, pc_op, cond, status, k, reg_in,
    output rom_addr, pc_plus4, stk_full, stk_empty, stk_err
  );
endinterface

// File: rtl/pc_unit_ret_stack.sv
// Return-address LIFO: push writes at count, pop reads count-1.
// The full/empty flags are registered from the next count value.
module ret_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CW-1:0] count, count_next, count_m1;
  logic [W-1:0]  mem [DEPTH];
  logic          do_push, do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty && !push;
  assign count_m1 = count - CW'(1);
  assign dout     = mem[count_m1[AW-1:0]];

  always_comb begin
    count_next = count;
    if (do_push)
      count_next = count + CW'(1);
    else if (do_pop)
      count_next = count_m1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage is left uninitialised on reset; count alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[count[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter and fetch-address stage.
// Applies one PC operation per enabled edge: increment, branch, jump, register jump, call or return.
module pc_unit
  import controlpath_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       STACK_DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_unit_if.slave bus
);
  logic [ADDR_W-1:0] pc, pc_next, pc_inc, offset, stk_dout;
  logic              push, pop, err, err_set, taken;
  logic              full, empty;
  logic              unused_bits;

  assign pc_inc = pc + ADDR_W'(4);
  // Word offset from k: the low bits shifted up two, so the sign comes from k[ADDR_W-3].
  assign offset = {bus.k[ADDR_W-3:0], 2'b00};
  assign taken  = cond_eval(bus.cond, bus.status);

  assign unused_bits = ^{bus.k, bus.reg_in};

  always_comb begin
    pc_next = pc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (bus.pc_en) begin
      case (pc_op_e'(bus.pc_op))
        PC_OP_INC: pc_next = pc_inc;
        PC_OP_BR:  pc_next = taken ? pc + offset : pc_inc;
        PC_OP_JMP: pc_next = {bus.k[ADDR_W-1:2], 2'b00};
        PC_OP_JR:  pc_next = {bus.reg_in[ADDR_W-1:2], 2'b00};
        PC_OP_CALL: begin
          if (full) begin
            err_set = 1'b1;
          end else begin
            push    = 1'b1;
            pc_next = pc + offset;
          end
        end
        PC_OP_RET: begin
          if (empty) begin
            err_set = 1'b1;
          end else begin
            pop     = 1'b1;
            pc_next = stk_dout;
          end
        end
        default: pc_next = pc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= RESET_PC;
      err <= 1'b0;
    end else begin
      pc  <= pc_next;
      err <= err || err_set;
    end
  end

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_dout),
    .full  (full),
    .empty (empty)
  );

  assign bus.rom_addr  = pc;
  assign bus.pc_plus4  = pc_inc;
  assign bus.stk_full  = full;
  assign bus.stk_empty = empty;
  assign bus.stk_err   = err;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit using immediate assertions.
module tb_pc_unit;
  import controlpath_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pc_unit_if #(.ADDR_W(32)) bus ();

  pc_unit #(
    .ADDR_W      (32),
    .RESET_PC    (32'h0),
    .STACK_DEPTH (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic [2:0] op, input logic [3:0] c,
                      input logic [3:0] s, input logic [63:0] kk, input logic [63:0] r);
    bus.pc_en  = en;
    bus.pc_op  = op;
    bus.cond   = c;
    bus.status = s;
    bus.k      = kk;
    bus.reg_in = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.pc_en = 1'b0; bus.pc_op = '0; bus.cond = '0;
    bus.status = '0; bus.k = '0; bus.reg_in = '0;
    #12;
    chk("reset_pc", bus.rom_addr, 32'h0);
    chk("reset_empty", {31'b0, bus.stk_empty}, 32'd1);
    chk("reset_full", {31'b0, bus.stk_full}, 32'd0);
    chk("reset_err", {31'b0, bus.stk_err}, 32'd0);
    chk("reset_plus4", bus.pc_plus4, 32'h4);
    @(negedge clk);
    rst_n = 1'b1;

    // Increment
    step(1, PC_OP_INC, 0, 0, 0, 0); chk("inc1", bus.rom_addr, 32'h4);
    step(1, PC_OP_INC, 0, 0, 0, 0); chk("inc2", bus.rom_addr, 32'h8);
    step(1, PC_OP_INC, 0, 0, 0, 0); chk("inc3", bus.rom_addr, 32'hC);

    // Branches
    step(1, PC_OP_JMP, 0, 0, 64'h100, 0); chk("jmp100", bus.rom_addr, 32'h100);
    step(1, PC_OP_BR, COND_EQ, 4'b0001, 64'hFFFF_FFFF_FFFF_FFFE, 0); chk("br_eq_taken", bus.rom_addr, 32'hF8);
    step(1, PC_OP_JMP, 0, 0, 64'h100, 0);
    step(1, PC_OP_BR, COND_EQ, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFE, 0); chk("br_eq_not", bus.rom_addr, 32'h104);
    step(1, PC_OP_BR, COND_GT, 4'b1010, 64'd4, 0); chk("br_gt_taken", bus.rom_addr, 32'h114);
    step(1, PC_OP_BR, COND_NV, 4'b1111, 64'd4, 0); chk("br_nv", bus.rom_addr, 32'h118);
    step(1, PC_OP_BR, COND_LT, 4'b1010, 64'd4, 0); chk("br_lt_not", bus.rom_addr, 32'h11C);
    step(1, PC_OP_BR, COND_HI, 4'b0100, 64'd1, 0); chk("br_hi_taken", bus.rom_addr, 32'h120);
    step(1, PC_OP_HOLD, 0, 0, 64'h500, 0); chk("hold", bus.rom_addr, 32'h120);
    step(1, PC_OP_RSVD, 0, 0, 64'h500, 0); chk("reserved", bus.rom_addr, 32'h120);

    // Jumps and wrap
    step(1, PC_OP_JMP, 0, 0, 64'h203, 0); chk("jmp203", bus.rom_addr, 32'h200);
    step(1, PC_OP_JR, 0, 0, 0, 64'hFFFF_FFFE); chk("jr", bus.rom_addr, 32'hFFFF_FFFC);
    chk("plus4_wrap", bus.pc_plus4, 32'h0);
    step(1, PC_OP_INC, 0, 0, 0, 0); chk("inc_wrap", bus.rom_addr, 32'h0);

    // Nested calls
    step(1, PC_OP_JMP, 0, 0, 64'h10, 0);
    step(1, PC_OP_CALL, 0, 0, 64'd4, 0); chk("call1", bus.rom_addr, 32'h20);
    chk("call1_empty", {31'b0, bus.stk_empty}, 32'd0);
    step(1, PC_OP_INC, 0, 0, 0, 0); chk("at24", bus.rom_addr, 32'h24);
    step(1, PC_OP_CALL, 0, 0, 64'd4, 0); chk("call2", bus.rom_addr, 32'h34);
    step(1, PC_OP_RET, 0, 0, 0, 0); chk("ret1", bus.rom_addr, 32'h28);
    step(1, PC_OP_RET, 0, 0, 0, 0); chk("ret2", bus.rom_addr, 32'h14);
    chk("ret2_empty", {31'b0, bus.stk_empty}, 32'd1);

    // Fill the stack, overflow, drain, underflow
    for (int i = 0; i < 8; i++) step(1, PC_OP_CALL, 0, 0, 64'd1, 0);
    chk("fill_pc", bus.rom_addr, 32'h34);
    chk("fill_full", {31'b0, bus.stk_full}, 32'd1);
    chk("fill_err", {31'b0, bus.stk_err}, 32'd0);
    step(1, PC_OP_CALL, 0, 0, 64'd1, 0); chk("ovf_pc", bus.rom_addr, 32'h34);
    chk("ovf_err", {31'b0, bus.stk_err}, 32'd1);
    for (int j = 0; j < 8; j++) begin
      step(1, PC_OP_RET, 0, 0, 0, 0);
      chk("drain", bus.rom_addr, 32'h34 - 32'(4 * j));
    end
    chk("drain_empty", {31'b0, bus.stk_empty}, 32'd1);
    chk("drain_full", {31'b0, bus.stk_full}, 32'd0);
    step(1, PC_OP_RET, 0, 0, 0, 0); chk("udf_pc", bus.rom_addr, 32'h18);
    chk("udf_err", {31'b0, bus.stk_err}, 32'd1);

    // Disabled ops
    step(0, PC_OP_CALL, 0, 0, 64'd4, 0); chk("dis_call_pc", bus.rom_addr, 32'h18);
    chk("dis_call_empty", {31'b0, bus.stk_empty}, 32'd1);
    step(0, PC_OP_INC, 0, 0, 0, 0); chk("dis_inc_pc", bus.rom_addr, 32'h18);
    step(1, PC_OP_CALL, 0, 0, 64'd1, 0); chk("call_pre_rst", bus.rom_addr, 32'h1C);
    chk("call_pre_rst_empty", {31'b0, bus.stk_empty}, 32'd0);

    // Asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1;
    chk("arst_pc", bus.rom_addr, 32'h0);
    chk("arst_err", {31'b0, bus.stk_err}, 32'd0);
    chk("arst_empty", {31'b0, bus.stk_empty}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, PC_OP_INC, 0, 0, 0, 0); chk("post_rst_inc", bus.rom_addr, 32'h4);
    step(1, PC_OP_RET, 0, 0, 0, 0); chk("post_rst_ret", bus.rom_addr, 32'h4);
    chk("post_rst_err", {31'b0, bus.stk_err}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
